// File: rtl/tt_rng_collector.sv
// tt_rng_collector: packs debiased random bits MSB-first into WIDTH-bit words,
// presents them on a valid/ready port and runs a repetition-count health test.
// A completed word that cannot reach the port waits in the shift register (HOLD)
// while later bits are dropped and counted.
module tt_rng_collector #(
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    output logic [WIDTH-1:0] o_word_out,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic             o_health_fail,
    input  logic             i_clr_fail,
    output logic [7:0]       o_drop_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_run;
    logic             r_last;
    logic [WIDTH-1:0] r_word;
    logic             r_wvalid;
    logic             r_fail;
    logic [7:0]       r_drop;

    logic             w_acc;
    logic             w_pop;
    logic             w_port_free;
    logic [RW-1:0]    w_run_nxt;
    logic             w_trip;
    logic [WIDTH-1:0] w_shifted;

    // Bits only count while collecting or holding; FAIL ignores the stream.
    assign w_acc       = i_en & i_bit_valid & (r_state != ST_FAIL);
    assign w_pop       = r_wvalid & i_word_ready;
    assign w_port_free = ~r_wvalid | w_pop;
    assign w_run_nxt   = ((r_run != '0) && (i_bit_in == r_last)) ? r_run + 1'b1 : RW'(1);
    assign w_trip      = w_acc & (w_run_nxt == RW'(REP_LIMIT));
    assign w_shifted   = {r_shreg[WIDTH-2:0], i_bit_in};

    assign o_word_out    = r_word;
    assign o_word_valid  = r_wvalid;
    assign o_health_fail = r_fail;
    assign o_drop_cnt    = r_drop;

    // Collector state machine, health test, output register and drop counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_COLLECT;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_run    <= '0;
            r_last   <= 1'b0;
            r_word   <= '0;
            r_wvalid <= 1'b0;
            r_fail   <= 1'b0;
            r_drop   <= '0;
        end else begin
            // A pop empties the port unless a new word loads on the same edge below.
            if (w_pop) r_wvalid <= 1'b0;

            if (w_acc) begin
                r_run  <= w_run_nxt;
                r_last <= i_bit_in;
            end

            case (r_state)
                ST_COLLECT: begin
                    if (w_trip) begin
                        // Trip beats word completion: the partial word is lost.
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end else if (w_acc) begin
                        r_shreg <= w_shifted;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_cnt <= '0;
                            if (w_port_free) begin
                                r_word   <= w_shifted;
                                r_wvalid <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Every accepted bit here is discarded, including one on the
                    // transfer cycle or one that trips the health test.
                    if (w_acc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                    if (w_trip) begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end else if (w_port_free) begin
                        r_word   <= r_shreg;
                        r_wvalid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_COLLECT;
                    end
                end
                ST_FAIL: begin
                    if (i_clr_fail) begin
                        r_fail  <= 1'b0;
                        r_run   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_rng_collector.sv
// tb_tt_rng_collector: randomized phases against a queue-based reference model.
// The stimulus process advances the model and pushes expected words; the monitor
// pops them on each handshake and checks the port, health flag and drop count.
module tb_tt_rng_collector;

    localparam int W   = 8;
    localparam int REP = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         word_ready = 1'b0;
    logic         clr_fail = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         health_fail;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    tt_rng_collector #(.WIDTH(W), .REP_LIMIT(REP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_bit_in     (bit_in),
        .i_bit_valid  (bit_valid),
        .o_word_out   (word_out),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_health_fail(health_fail),
        .i_clr_fail   (clr_fail),
        .o_drop_cnt   (drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 0;

    // Reference model: pending bits as a queue, port as a queue of at most one word.
    int           m_run    = 0;
    bit           m_last   = 0;
    bit           m_failed = 0;
    bit           m_held   = 0;
    logic [W-1:0] m_hword  = '0;
    int           m_drop   = 0;
    bit           pbits[$];
    logic [W-1:0] expq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_step();
        logic [W-1:0] w;
        if (!rst_n) begin
            m_run = 0; m_last = 0; m_failed = 0; m_held = 0; m_drop = 0;
            pbits.delete();
            expq.delete();
            return;
        end
        if (m_failed) begin
            if (clr_fail) begin
                m_failed = 0;
                m_run    = 0;
                pbits.delete();
            end
            return;
        end
        if (en && bit_valid) begin
            m_run  = (m_run != 0 && bit_in == m_last) ? m_run + 1 : 1;
            m_last = bit_in;
            if (m_held && m_drop < 255) m_drop++;
            if (m_run == REP) begin
                m_failed = 1;
                m_held   = 0;
                pbits.delete();
                return;
            end
            if (!m_held) begin
                pbits.push_back(bit_in);
                if (pbits.size() == W) begin
                    w = '0;
                    foreach (pbits[i]) w = {w[W-2:0], pbits[i]};
                    pbits.delete();
                    if (expq.size() == 0) expq.push_back(w);
                    else begin
                        m_held  = 1;
                        m_hword = w;
                    end
                    return;
                end
            end
        end
        if (m_held && expq.size() == 0) begin
            expq.push_back(m_hword);
            m_held = 0;
        end
    endtask

    // One clock of stimulus: commit the model for the edge just taken, then
    // draw new inputs. mode 0: random bits, 1: mostly alternating, 2: long runs.
    task automatic drive(input int en_p, input int bv_p, input int rdy_p,
                         input int clr_p, input int rst_p, input int mode);
        @(posedge clk);
        #2;
        model_step();
        rst_n      = !pct(rst_p);
        en         = pct(en_p);
        bit_valid  = pct(bv_p);
        word_ready = pct(rdy_p);
        clr_fail   = pct(clr_p);
        case (mode)
            0:       bit_in = 1'($urandom_range(1));
            1:       bit_in = pct(10) ? bit_in : ~bit_in;
            default: bit_in = pct(92) ? bit_in : ~bit_in;
        endcase
    endtask

    // Monitor: compare on the falling edge, pop the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("word_valid", int'(word_valid), int'(expq.size() != 0));
                if (word_valid && expq.size() != 0) begin
                    chk("word_out", int'(word_out), int'(expq[0]));
                    if (word_ready) void'(expq.pop_front());
                end
                chk("health_fail", int'(health_fail), int'(m_failed));
                chk("drop_cnt", int'(drop_cnt), m_drop);
            end
        end
    end

    initial begin
        // Reset for a few cycles, then release.
        repeat (3) drive(0, 0, 0, 0, 100, 0);
        chk("reset_word_out", int'(word_out), 0);
        chk("reset_drop_cnt", int'(drop_cnt), 0);
        // Mixed traffic with occasional reset and clears.
        repeat (600) drive(90, 70, 60, 3, 1, 0);
        // Clear any pending failure, drain the port.
        repeat (3) drive(0, 0, 100, 100, 0, 0);
        // Backpressure with disabled bits in the middle, then a long dropping burst.
        repeat (20) drive(0, 100, 0, 0, 0, 1);
        repeat (320) drive(100, 100, 0, 0, 0, 1);
        chk("drop_saturate", int'(drop_cnt), 255);
        repeat (20) drive(0, 100, 100, 0, 0, 1);
        // Long runs to trip the health test, with clears.
        repeat (500) drive(95, 80, 70, 6, 0, 2);
        // Ready always high: completion on the same cycle as a pop.
        repeat (300) drive(100, 100, 100, 2, 1, 0);
        drive(0, 0, 100, 0, 0, 0);
        @(negedge clk);
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
